// File: rtl/ccx_mem_arbiter.sv
// Two-requester arbiter sharing one memory target between fetch (m0) and
// data (m1) buses. Ports: g_clk/g_reset, m0_*/m1_* requester buses
// (req, rtype, wen, addr, strb, wdata, prv in; gnt, err, rdata out) and
// the downstream s_* request bus with s_gnt/s_err/s_rdata coming back.
module ccx_mem_arbiter #(
    parameter int AW        = 39,
    parameter int DW        = 64,
    parameter int PRIO_MODE = 0
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            m0_req,
    input  logic            m0_rtype,
    input  logic            m0_wen,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW/8-1:0] m0_strb,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [1:0]      m0_prv,
    output logic            m0_gnt,
    output logic            m0_err,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_req,
    input  logic            m1_rtype,
    input  logic            m1_wen,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW/8-1:0] m1_strb,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [1:0]      m1_prv,
    output logic            m1_gnt,
    output logic            m1_err,
    output logic [DW-1:0]   m1_rdata,
    output logic            s_req,
    output logic            s_rtype,
    output logic            s_wen,
    output logic [AW-1:0]   s_addr,
    output logic [DW/8-1:0] s_strb,
    output logic [DW-1:0]   s_wdata,
    output logic [1:0]      s_prv,
    input  logic            s_gnt,
    input  logic            s_err,
    input  logic [DW-1:0]   s_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        LOCK0,
        LOCK1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic last_win;
    logic rsp_vld;
    logic rsp_own;
    logic sel;
    logic sel_vld;
    logic grant;

    always_comb begin
        sel       = 1'b0;
        sel_vld   = 1'b0;
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    sel = (PRIO_MODE != 0) ? 1'b1 : ~last_win;
                end else begin
                    sel = m1_req;
                end
                sel_vld = m0_req | m1_req;
            end
            LOCK0: begin
                sel     = 1'b0;
                sel_vld = m0_req;
            end
            LOCK1: begin
                sel     = 1'b1;
                sel_vld = m1_req;
            end
            default: begin
                sel     = 1'b0;
                sel_vld = 1'b0;
            end
        endcase
        // Reset must silence the bus immediately, not at the next edge.
        if (g_reset) begin
            sel_vld = 1'b0;
        end
        grant = sel_vld & s_gnt;
        // A dropped locked request (abort) also falls back to IDLE.
        if (grant || !sel_vld) begin
            state_nxt = IDLE;
        end else begin
            state_nxt = sel ? LOCK1 : LOCK0;
        end
    end

    assign s_req   = sel_vld;
    assign s_rtype = sel_vld & (sel ? m1_rtype : m0_rtype);
    assign s_wen   = sel_vld & (sel ? m1_wen : m0_wen);
    assign s_addr  = sel_vld ? (sel ? m1_addr : m0_addr) : '0;
    assign s_strb  = sel_vld ? (sel ? m1_strb : m0_strb) : '0;
    assign s_wdata = sel_vld ? (sel ? m1_wdata : m0_wdata) : '0;
    assign s_prv   = sel_vld ? (sel ? m1_prv : m0_prv) : '0;

    assign m0_gnt = grant & ~sel;
    assign m1_gnt = grant & sel;

    assign m0_rdata = (rsp_vld & ~rsp_own) ? s_rdata : '0;
    assign m1_rdata = (rsp_vld & rsp_own) ? s_rdata : '0;
    assign m0_err   = rsp_vld & ~rsp_own & s_err;
    assign m1_err   = rsp_vld & rsp_own & s_err;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state    <= IDLE;
            last_win <= 1'b1;
            rsp_vld  <= 1'b0;
            rsp_own  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rsp_vld <= grant;
            if (grant) begin
                last_win <= sel;
                rsp_own  <= sel;
            end
        end
    end

endmodule
